// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the unified-memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  // Arbiter FSM state codes
  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_ACC_CPU = 2'd1,
    ARB_ACC_DBG = 2'd2,
    ARB_RESP    = 2'd3
  } arbState_t;

  // Which requester owns the access currently in flight
  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arb_fairness.sv
// Saturating CPU-grant counter used to bound DBG starvation.
module mem_arb_fairness #(
  parameter  int MAX_CPU_BURST = 4,
  localparam int CNT_W         = $clog2(MAX_CPU_BURST + 1)
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iInc,
  input  logic iClr,
  output logic oFull
);

  logic [CNT_W-1:0] cnt;

  // Clear has priority; increment stops at the burst limit
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst)                cnt <= '0;
    else if (iClr)            cnt <= '0;
    else if (iInc && !oFull)  cnt <= cnt + 1'b1;
  end

  assign oFull = (cnt == CNT_W'(MAX_CPU_BURST));

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port (CPU / debug) arbiter in front of the single synchronous RAM.
// One access every two cycles: ACC issues the strobe, RESP returns data and re-arbitrates.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int DATA_W        = DEF_DATA_W,
  parameter int MAX_CPU_BURST = 4
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iCpuReq,
  input  logic              iCpuWe,
  input  logic [ADDR_W-1:0] iCpuAddr,
  input  logic [DATA_W-1:0] iCpuWData,
  output logic              oCpuGnt,
  output logic              oCpuValid,
  output logic [DATA_W-1:0] oCpuRData,
  input  logic              iDbgReq,
  input  logic              iDbgWe,
  input  logic [ADDR_W-1:0] iDbgAddr,
  input  logic [DATA_W-1:0] iDbgWData,
  output logic              oDbgGnt,
  output logic              oDbgValid,
  output logic [DATA_W-1:0] oDbgRData,
  input  logic              iDbgHalt,
  output logic [ADDR_W-1:0] oMemAddr,
  output logic [DATA_W-1:0] oMemWData,
  output logic              oMemWe,
  output logic              oMemRe,
  input  logic [DATA_W-1:0] iMemRData
);

  arbState_t         state, nextState;
  owner_t            owner;
  logic              grantCpu, grantDbg;
  logic              cpuElig, fairFull;
  logic              latWe;
  logic [ADDR_W-1:0] latAddr;
  logic [DATA_W-1:0] latWData;
  logic [DATA_W-1:0] cpuHold, dbgHold;
  logic              inAcc, respRead;

  assign cpuElig = iCpuReq & ~iDbgHalt;

  mem_arb_fairness #(.MAX_CPU_BURST(MAX_CPU_BURST)) uFair (
    .iClk  (iClk),
    .iRst  (iRst),
    .iInc  (grantCpu & iDbgReq),
    .iClr  (grantDbg | ~iDbgReq),
    .oFull (fairFull)
  );

  // State register
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) state <= ARB_IDLE;
    else       state <= nextState;
  end

  // Next state and grant decision; arbitration only happens in IDLE and RESP
  always_comb begin
    nextState = state;
    grantCpu  = 1'b0;
    grantDbg  = 1'b0;
    case (state)
      ARB_IDLE, ARB_RESP: begin
        if (cpuElig && !(iDbgReq && fairFull)) grantCpu = 1'b1;
        else if (iDbgReq)                      grantDbg = 1'b1;
        if (grantCpu)      nextState = ARB_ACC_CPU;
        else if (grantDbg) nextState = ARB_ACC_DBG;
        else               nextState = ARB_IDLE;
      end
      ARB_ACC_CPU, ARB_ACC_DBG: nextState = ARB_RESP;
      default:                  nextState = ARB_IDLE;
    endcase
  end

  // Latch the winner's attributes on the edge entering ACC
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      owner    <= OWN_CPU;
      latWe    <= 1'b0;
      latAddr  <= '0;
      latWData <= '0;
    end else if (grantCpu) begin
      owner    <= OWN_CPU;
      latWe    <= iCpuWe;
      latAddr  <= iCpuAddr;
      latWData <= iCpuWData;
    end else if (grantDbg) begin
      owner    <= OWN_DBG;
      latWe    <= iDbgWe;
      latAddr  <= iDbgAddr;
      latWData <= iDbgWData;
    end
  end

  assign inAcc    = (state == ARB_ACC_CPU) || (state == ARB_ACC_DBG);
  assign respRead = (state == ARB_RESP) && !latWe;

  // Capture completed read data so each port's rdata persists until its next read
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      cpuHold <= '0;
      dbgHold <= '0;
    end else if (respRead) begin
      if (owner == OWN_CPU) cpuHold <= iMemRData;
      else                  dbgHold <= iMemRData;
    end
  end

  // Strobes are decoded from state so an async reset drops them immediately
  assign oMemAddr  = latAddr;
  assign oMemWData = latWData;
  assign oMemWe    = inAcc & latWe;
  assign oMemRe    = inAcc & ~latWe;

  assign oCpuGnt   = (state == ARB_ACC_CPU);
  assign oDbgGnt   = (state == ARB_ACC_DBG);
  assign oCpuValid = (state == ARB_RESP) && (owner == OWN_CPU);
  assign oDbgValid = (state == ARB_RESP) && (owner == OWN_DBG);
  assign oCpuRData = (respRead && owner == OWN_CPU) ? iMemRData : cpuHold;
  assign oDbgRData = (respRead && owner == OWN_DBG) ? iMemRData : dbgHold;

endmodule
